// File: rtl/btn_pkg.sv
// Shared button definitions: bit indices, PCU button-status codes, debounce FSM states.
package btn_pkg;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned BS_W    = 3;

    // Bit positions inside btn_raw / btn_level
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_D = 3;
    localparam int unsigned BTN_R = 4;

    // Button-status codes, shared with the PCU CSR write logic
    localparam logic [BS_W-1:0] BS_NONE = 3'd0;
    localparam logic [BS_W-1:0] BS_U    = 3'd1;
    localparam logic [BS_W-1:0] BS_D    = 3'd2;
    localparam logic [BS_W-1:0] BS_L    = 3'd3;
    localparam logic [BS_W-1:0] BS_R    = 3'd4;
    localparam logic [BS_W-1:0] BS_C    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_CNT,
        ST_PRESSED,
        ST_REL_CNT
    } btn_state_e;

    // Priority encoder matching the PCU bs field: u > d > l > r > c
    function automatic logic [BS_W-1:0] bs_encode(input logic [NUM_BTN-1:0] fire);
        logic [BS_W-1:0] code;
        code = BS_NONE;
        if (fire[BTN_U])      code = BS_U;
        else if (fire[BTN_D]) code = BS_D;
        else if (fire[BTN_L]) code = BS_L;
        else if (fire[BTN_R]) code = BS_R;
        else if (fire[BTN_C]) code = BS_C;
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchroniser, press/release debounce FSM, accept strobe and level.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic accept_c,
    output logic level
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;

    assign s = sync_q[1];

    // Accept fires in the cycle the last stable sample is seen; the top registers it
    assign accept_c = (state == ST_PRESS_CNT) && s && (cnt == CNT_LAST);

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[0], raw};
    end

    // Debounce FSM with saturating stability counter and registered level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRESS_CNT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_PRESS_CNT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state <= ST_REL_CNT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_REL_CNT: begin
                    if (s) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_cond.sv
// Conditions the five board buttons into one-cycle PCU press pulses with a re-arm lockout.
module button_cond
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REARM_CYCLES    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               btn_en,
    output logic               butc,
    output logic               butu,
    output logic               butl,
    output logic               butd,
    output logic               butr,
    output logic [BS_W-1:0]    btn_code,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int unsigned LOCK_W = (REARM_CYCLES > 0) ? $clog2(REARM_CYCLES + 1) : 1;

    logic [NUM_BTN-1:0] accept_c;
    logic [NUM_BTN-1:0] fire_c;
    logic [LOCK_W-1:0]  lock_cnt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk      (clk),
            .rstn     (rstn),
            .raw      (btn_raw[i]),
            .accept_c (accept_c[i]),
            .level    (btn_level[i])
        );
    end

    // Accepts survive only when enabled and outside the lockout window; others are dropped
    assign fire_c = accept_c & {NUM_BTN{btn_en & (lock_cnt == '0)}};

    // Register pulses and code, and run the shared re-arm lockout counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            butc     <= 1'b0;
            butu     <= 1'b0;
            butl     <= 1'b0;
            butd     <= 1'b0;
            butr     <= 1'b0;
            btn_code <= BS_NONE;
            lock_cnt <= '0;
        end else begin
            butc     <= fire_c[BTN_C];
            butu     <= fire_c[BTN_U];
            butl     <= fire_c[BTN_L];
            butd     <= fire_c[BTN_D];
            butr     <= fire_c[BTN_R];
            btn_code <= bs_encode(fire_c);
            if (|fire_c)
                lock_cnt <= LOCK_W'(REARM_CYCLES);
            else if (lock_cnt != '0)
                lock_cnt <= lock_cnt - LOCK_W'(1);
        end
    end

endmodule

// File: tb/tb_button_cond.sv
// Directed bench for button_cond with DEBOUNCE_CYCLES=4, REARM_CYCLES=3.
module tb_button_cond;
    import btn_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned RE  = 3;

    logic       clk;
    logic       rstn;
    logic [4:0] btn_raw;
    logic       btn_en;
    logic       butc, butu, butl, butd, butr;
    logic [2:0] btn_code;
    logic [4:0] btn_level;
    logic [4:0] pulses;

    int total = 0;
    int bad   = 0;

    assign pulses = {butr, butd, butl, butu, butc};

    button_cond #(
        .DEBOUNCE_CYCLES (DEB),
        .REARM_CYCLES    (RE)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_raw   (btn_raw),
        .btn_en    (btn_en),
        .butc      (butc),
        .butu      (butu),
        .butl      (butl),
        .butd      (butd),
        .butr      (butr),
        .btn_code  (btn_code),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] bnc;
        bnc = 12'b0000_0011_0111;

        rstn    = 1'b0;
        btn_raw = '0;
        btn_en  = 1'b1;
        ticks(3);
        chk("rst_pulses", 32'(pulses), 0);
        chk("rst_code", 32'(btn_code), 0);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_lock", 32'(u_dut.lock_cnt), 0);
        rstn = 1'b1;
        ticks(3);

        // Clean press on u: pulse on the 6th edge after the input changes
        btn_raw[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_pre", 32'(pulses), 0);
        end
        tick();
        chk("t1_pulse", 32'(pulses), 'h02);
        chk("t1_code", 32'(btn_code), 1);
        chk("t1_level", 32'(btn_level), 'h02);
        tick();
        chk("t1_after", 32'(pulses), 0);
        chk("t1_code0", 32'(btn_code), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_held", 32'(pulses), 0);
            chk("t1_held_lvl", 32'(btn_level), 'h02);
        end
        btn_raw[1] = 1'b0;
        ticks(5);
        chk("t1_rel_lvl_hi", 32'(btn_level), 'h02);
        tick();
        chk("t1_rel_lvl_lo", 32'(btn_level), 0);
        ticks(3);

        // Bounce on d: never four consecutive stable samples
        for (int i = 0; i < 12; i++) begin
            btn_raw[3] = bnc[i];
            tick();
            chk("t2_bounce", 32'(pulses), 0);
            chk("t2_bounce_lvl", 32'(btn_level), 0);
        end
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_pre", 32'(pulses), 0);
        end
        tick();
        chk("t2_pulse", 32'(pulses), 'h08);
        chk("t2_code", 32'(btn_code), 2);
        btn_raw[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_post", 32'(pulses), 0);
        end
        chk("t2_lvl_end", 32'(btn_level), 0);

        // Simultaneous c and r
        btn_raw = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_pre", 32'(pulses), 0);
        end
        tick();
        chk("t3_pulse", 32'(pulses), 'h11);
        chk("t3_code", 32'(btn_code), 4);
        chk("t3_lock", 32'(u_dut.lock_cnt), 3);
        chk("t3_level", 32'(btn_level), 'h11);
        btn_raw = '0;
        ticks(12);

        // Lockout: l accepted two cycles after the u pulse is dropped
        btn_raw[1] = 1'b1;
        ticks(2);
        btn_raw[2] = 1'b1;
        ticks(3);
        chk("t4_pre", 32'(pulses), 0);
        tick();
        chk("t4_u_pulse", 32'(pulses), 'h02);
        btn_raw[1] = 1'b0;
        tick();
        chk("t4_gap", 32'(pulses), 0);
        tick();
        chk("t4_l_dropped", 32'(pulses), 0);
        chk("t4_l_level", 32'(btn_level[2]), 1);
        chk("t4_lock_mid", 32'(u_dut.lock_cnt), 1);
        btn_raw[2] = 1'b0;
        ticks(10);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_pre2", 32'(pulses), 0);
        end
        tick();
        chk("t4_l_pulse", 32'(pulses), 'h04);
        chk("t4_l_code", 32'(btn_code), 3);
        btn_raw = '0;
        ticks(10);

        // Disabled accept is dropped and not deferred
        btn_en     = 1'b0;
        btn_raw[0] = 1'b1;
        ticks(5);
        tick();
        chk("t5_no_pulse", 32'(pulses), 0);
        chk("t5_level", 32'(btn_level[0]), 1);
        chk("t5_lock", 32'(u_dut.lock_cnt), 0);
        btn_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_held_en", 32'(pulses), 0);
        end
        btn_raw[0] = 1'b0;
        ticks(10);

        // Async reset in mid-lockout with r mid-count, then full latency after release
        btn_raw = 5'b00010;
        ticks(3);
        btn_raw = 5'b10010;
        ticks(3);
        chk("t6_u_pulse", 32'(pulses), 'h02);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_pulses", 32'(pulses), 0);
        chk("t6_async_level", 32'(btn_level), 0);
        chk("t6_async_lock", 32'(u_dut.lock_cnt), 0);
        ticks(2);
        chk("t6_in_rst", 32'(pulses), 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_pre", 32'(pulses), 0);
        end
        tick();
        chk("t6_pulse", 32'(pulses), 'h12);
        chk("t6_code", 32'(btn_code), 1);
        tick();
        chk("t6_after", 32'(pulses), 0);
        btn_raw = '0;
        ticks(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
